// File: rtl/exp_norm_pipe.sv
// exp_norm_pipe
// Two-stage elastic exponent normalisation for the FP adder/subtractor.
// Stage 1 captures the biased exponent, update mode and shift count.
// Stage 2 holds the updated, saturated exponent with its overflow/underflow
// classification. The block also keeps sticky exception flags.
// Both stages use a valid/ready handshake. Back-pressure from the packer
// stalls the pipe without dropping or duplicating results.

module exp_norm_pipe #(
    parameter int W_Exp   = 8,
    parameter int W_Shift = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_Exp-1:0]   exp_in,
    input  logic [1:0]         mode,
    input  logic [W_Shift-1:0] shift_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_Exp-1:0]   exp_out,
    output logic               overflow,
    output logic               underflow,
    input  logic               clr_flags,
    output logic               ovf_sticky,
    output logic               unf_sticky
);

    // Working width: wide enough for exponent+1 and for a negative
    // exponent-minus-shift result, with a sign bit on top.
    localparam int WC = ((W_Exp > W_Shift) ? W_Exp : W_Shift) + 2;

    // Largest finite biased exponent (all-ones minus one), zero-extended.
    localparam logic [WC-1:0] U_LIMIT = {{(WC-W_Exp){1'b0}}, {(W_Exp-1){1'b1}}, 1'b0};
    localparam logic [WC-1:0] ONE_WC  = {{(WC-1){1'b0}}, 1'b1};
    localparam logic [WC-1:0] ZERO_WC = {WC{1'b0}};

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_SUB  = 2'b10;
    localparam logic [1:0] MODE_ZERO = 2'b11;

    // Stage 1 capture registers
    logic               s1_valid_r;
    logic [W_Exp-1:0]   s1_exp_r;
    logic [1:0]         s1_mode_r;
    logic [W_Shift-1:0] s1_shift_r;

    // Stage 2 result registers
    logic               s2_valid_r;
    logic [W_Exp-1:0]   exp_out_r;
    logic               ovf_r;
    logic               unf_r;
    logic               ovf_sticky_r;
    logic               unf_sticky_r;

    // Handshake helpers
    logic s2_free_s;
    logic s1_adv_s;
    logic in_fire_s;

    // Stage-2 next-state values
    logic [WC-1:0]    e_ext_s;
    logic [WC-1:0]    sh_ext_s;
    logic [WC-1:0]    r_s;
    logic [W_Exp-1:0] exp_next_s;
    logic             ovf_next_s;
    logic             unf_next_s;

    // The ready path depends only on state and out_ready, never on in_valid.
    assign s2_free_s = !s2_valid_r || out_ready;
    assign s1_adv_s  = s1_valid_r && s2_free_s;
    assign in_ready  = !s1_valid_r || s2_free_s;
    assign in_fire_s = in_valid && in_ready;

    // Exponent update and overflow/underflow classification of the stage-1 contents
    always_comb begin
        e_ext_s    = {{(WC-W_Exp){1'b0}}, s1_exp_r};
        sh_ext_s   = {{(WC-W_Shift){1'b0}}, s1_shift_r};
        r_s        = ZERO_WC;
        exp_next_s = {W_Exp{1'b0}};
        ovf_next_s = 1'b0;
        unf_next_s = 1'b0;

        case (s1_mode_r)
            MODE_PASS: r_s = e_ext_s;
            MODE_INC:  r_s = e_ext_s + ONE_WC;
            MODE_SUB:  r_s = e_ext_s - sh_ext_s;
            default:   r_s = ZERO_WC;
        endcase

        if (s1_mode_r == MODE_ZERO) begin
            // Forced zero is never classified as an exception.
            exp_next_s = {W_Exp{1'b0}};
        end else if ((s1_mode_r == MODE_SUB) && (r_s[WC-1] || (r_s == ZERO_WC))) begin
            // Normalisation shift reached or passed the denormal boundary.
            exp_next_s = {W_Exp{1'b0}};
            unf_next_s = 1'b1;
        end else if (!r_s[WC-1] && (r_s > U_LIMIT)) begin
            // Saturate to the infinity exponent.
            exp_next_s = {W_Exp{1'b1}};
            ovf_next_s = 1'b1;
        end else begin
            exp_next_s = r_s[W_Exp-1:0];
        end
    end

    // Stage 1: capture a new input on accept, empty when it advances without refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_exp_r   <= {W_Exp{1'b0}};
            s1_mode_r  <= 2'b00;
            s1_shift_r <= {W_Shift{1'b0}};
        end else begin
            if (in_fire_s) begin
                s1_valid_r <= 1'b1;
                s1_exp_r   <= exp_in;
                s1_mode_r  <= mode;
                s1_shift_r <= shift_amt;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end
        end
    end

    // Stage 2: load the classified result, or drop valid once consumed; hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            exp_out_r  <= {W_Exp{1'b0}};
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s2_valid_r <= 1'b1;
                exp_out_r  <= exp_next_s;
                ovf_r      <= ovf_next_s;
                unf_r      <= unf_next_s;
            end else if (out_ready) begin
                s2_valid_r <= 1'b0;
            end
        end
    end

    // Sticky exception flags: a flagged stage-2 load takes priority over clr_flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else begin
            if (s1_adv_s && ovf_next_s) begin
                ovf_sticky_r <= 1'b1;
            end else if (clr_flags) begin
                ovf_sticky_r <= 1'b0;
            end

            if (s1_adv_s && unf_next_s) begin
                unf_sticky_r <= 1'b1;
            end else if (clr_flags) begin
                unf_sticky_r <= 1'b0;
            end
        end
    end

    assign out_valid  = s2_valid_r;
    assign exp_out    = exp_out_r;
    assign overflow   = ovf_r;
    assign underflow  = unf_r;
    assign ovf_sticky = ovf_sticky_r;
    assign unf_sticky = unf_sticky_r;

endmodule

// File: tb/tb_exp_norm_pipe.sv
// Directed testbench for exp_norm_pipe: a single-precision instance (a_*)
// and a double-precision instance (b_*) share the clock and reset.

module tb_exp_norm_pipe;

    logic clk;
    logic rst;

    // Single-precision instance signals
    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_exp_in, a_exp_out;
    logic [1:0] a_mode;
    logic [4:0] a_shift;
    logic       a_ovf, a_unf, a_clr, a_ovf_st, a_unf_st;

    // Double-precision instance signals
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [10:0] b_exp_in, b_exp_out;
    logic [1:0]  b_mode;
    logic [5:0]  b_shift;
    logic        b_ovf, b_unf, b_clr, b_ovf_st, b_unf_st;

    int pass_cnt;
    int total_cnt;

    exp_norm_pipe #(.W_Exp(8), .W_Shift(5)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .exp_in(a_exp_in), .mode(a_mode), .shift_amt(a_shift),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .exp_out(a_exp_out), .overflow(a_ovf), .underflow(a_unf),
        .clr_flags(a_clr), .ovf_sticky(a_ovf_st), .unf_sticky(a_unf_st)
    );

    exp_norm_pipe #(.W_Exp(11), .W_Shift(6)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .exp_in(b_exp_in), .mode(b_mode), .shift_amt(b_shift),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .exp_out(b_exp_out), .overflow(b_ovf), .underflow(b_unf),
        .clr_flags(b_clr), .ovf_sticky(b_ovf_st), .unf_sticky(b_unf_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one input to instance A for one cycle (it is ready in every use).
    task automatic send_a(input logic [7:0] e, input logic [1:0] m, input logic [4:0] sh);
        a_in_valid = 1'b1;
        a_exp_in   = e;
        a_mode     = m;
        a_shift    = sh;
        step();
        a_in_valid = 1'b0;
    endtask

    // One transaction on A with out_ready high: empty right after accept, result one edge later.
    task automatic run_a(input string tag, input logic [7:0] e, input logic [1:0] m,
                         input logic [4:0] sh, input logic [7:0] exp_e,
                         input logic ovf_e, input logic unf_e);
        send_a(e, m, sh);
        check({tag, "_lat_empty"}, {31'd0, a_out_valid}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, "_exp"},   {24'd0, a_exp_out},   {24'd0, exp_e});
        check({tag, "_ovf"},   {31'd0, a_ovf},       {31'd0, ovf_e});
        check({tag, "_unf"},   {31'd0, a_unf},       {31'd0, unf_e});
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b0;
        a_in_valid  = 1'b0; a_exp_in = 8'h00;  a_mode = 2'b00; a_shift = 5'd0;
        a_out_ready = 1'b1; a_clr = 1'b0;
        b_in_valid  = 1'b0; b_exp_in = 11'h000; b_mode = 2'b00; b_shift = 6'd0;
        b_out_ready = 1'b1; b_clr = 1'b0;

        // Reset state
        step();
        step();
        check("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_exp_out",   {24'd0, a_exp_out},   32'd0);
        check("rst_sticky",    {30'd0, a_ovf_st, a_unf_st}, 32'd0);
        rst = 1'b1;
        step();

        // Pass / increment
        run_a("pass_7f", 8'h7F, 2'b00, 5'd0, 8'h7F, 1'b0, 1'b0);
        run_a("inc_7f",  8'h7F, 2'b01, 5'd0, 8'h80, 1'b0, 1'b0);

        // Overflow boundary
        run_a("inc_fd",  8'hFD, 2'b01, 5'd0, 8'hFE, 1'b0, 1'b0);
        check("ovf_sticky_clear_yet", {31'd0, a_ovf_st}, 32'd0);
        run_a("inc_fe",  8'hFE, 2'b01, 5'd0, 8'hFF, 1'b1, 1'b0);
        check("ovf_sticky_set", {31'd0, a_ovf_st}, 32'd1);
        run_a("pass_ff", 8'hFF, 2'b00, 5'd0, 8'hFF, 1'b1, 1'b0);

        // Underflow boundary
        run_a("sub_5_4",  8'h05, 2'b10, 5'd4,  8'h01, 1'b0, 1'b0);
        check("unf_sticky_clear_yet", {31'd0, a_unf_st}, 32'd0);
        run_a("sub_5_5",  8'h05, 2'b10, 5'd5,  8'h00, 1'b0, 1'b1);
        check("unf_sticky_set", {31'd0, a_unf_st}, 32'd1);
        run_a("sub_5_31", 8'h05, 2'b10, 5'd31, 8'h00, 1'b0, 1'b1);
        run_a("zero_ff",  8'hFF, 2'b11, 5'd0,  8'h00, 1'b0, 1'b0);
        run_a("sub_80_3", 8'h80, 2'b10, 5'd3,  8'h7D, 1'b0, 1'b0);

        // Sticky flags: clear alone, then clear coinciding with an overflow load
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_ovf_sticky", {31'd0, a_ovf_st}, 32'd0);
        check("clr_unf_sticky", {31'd0, a_unf_st}, 32'd0);
        send_a(8'hFE, 2'b01, 5'd0);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_vs_set_ovf", {31'd0, a_ovf_st}, 32'd1);
        check("clr_vs_set_unf", {31'd0, a_unf_st}, 32'd0);
        check("clr_vs_set_out", {24'd0, a_exp_out}, 32'h0000_00FF);

        // Back-pressure: drain, then stream 4 values with out_ready low
        step();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_mode      = 2'b00;
        a_shift     = 5'd0;
        a_exp_in    = 8'h10;
        step();
        check("bp_ready_after1", {31'd0, a_in_ready}, 32'd1);
        a_exp_in = 8'h11;
        step();
        check("bp_ready_after2", {31'd0, a_in_ready}, 32'd0);
        check("bp_out_valid",    {31'd0, a_out_valid}, 32'd1);
        check("bp_first",        {24'd0, a_exp_out},   32'h0000_0010);
        a_exp_in = 8'h12;
        step();
        step();
        check("bp_hold_exp",   {24'd0, a_exp_out},  32'h0000_0010);
        check("bp_hold_ready", {31'd0, a_in_ready}, 32'd0);
        a_out_ready = 1'b1;
        #1;
        check("bp_ready_release", {31'd0, a_in_ready}, 32'd1);
        step();
        check("bp_out_11", {24'd0, a_exp_out}, 32'h0000_0011);
        a_exp_in = 8'h13;
        step();
        a_in_valid = 1'b0;
        check("bp_out_12", {24'd0, a_exp_out}, 32'h0000_0012);
        step();
        check("bp_out_13", {24'd0, a_exp_out},   32'h0000_0013);
        check("bp_valid3", {31'd0, a_out_valid}, 32'd1);
        step();
        check("bp_drained", {31'd0, a_out_valid}, 32'd0);

        // Reset mid-stream with a sticky flag set and results in flight
        send_a(8'hFE, 2'b01, 5'd0);
        a_in_valid = 1'b1;
        a_exp_in   = 8'h44;
        step();
        check("pre_rst_sticky", {31'd0, a_ovf_st}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("mid_rst_exp_out",   {24'd0, a_exp_out},   32'd0);
        check("mid_rst_flags",     {28'd0, a_ovf, a_unf, a_ovf_st, a_unf_st}, 32'd0);
        check("mid_rst_in_ready",  {31'd0, a_in_ready},  32'd1);
        a_in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("post_rst_empty", {30'd0, a_out_valid, a_in_ready}, 32'd1);
        run_a("post_rst_inc", 8'h7F, 2'b01, 5'd0, 8'h80, 1'b0, 1'b0);

        // Double precision overflow boundary
        b_in_valid = 1'b1;
        b_exp_in   = 11'h7FD;
        b_mode     = 2'b01;
        step();
        b_exp_in   = 11'h7FE;
        step();
        b_in_valid = 1'b0;
        check("dp_inc_7fd",     {21'd0, b_exp_out}, 32'h0000_07FE);
        check("dp_inc_7fd_ovf", {31'd0, b_ovf},     32'd0);
        step();
        check("dp_inc_7fe",        {21'd0, b_exp_out}, 32'h0000_07FF);
        check("dp_inc_7fe_ovf",    {31'd0, b_ovf},     32'd1);
        check("dp_inc_7fe_sticky", {31'd0, b_ovf_st},  32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
